instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning PC/word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning max cycles to wait for imem_ack (used only with FETCH_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin/restart execution at address 0.
REQ-006 SHALL have ports Jump, JumpReg, Branch, Stop, JAL  input  1 each  control-unit outputs for the current instruction.
REQ-007 SHALL have port branch_taken  input  1  branch condition result from ALU.
REQ-008 SHALL have port reg_target  input  32  rs value for jr.
REQ-009 SHALL have port stall  input  1  hold current instruction (multi-cycle ops).
REQ-010 SHALL have ports imem_req  output  1, imem_addr  output  ADDR_W, imem_rdata  input  32, imem_ack  input  1: instruction memory handshake.
REQ-011 SHALL have ports instr  output  32, opcode  output  6, instr_valid  output  1: decoded-side instruction stream.
REQ-012 SHALL have ports pc  output  ADDR_W, pc_link  output  ADDR_W (pc+1 for jal), halted  output  1, fault  output  1.

Function
REQ-013 SHALL implement FSM IDLE, FETCH, EXEC, HALT.
REQ-014 IDLE: start=1 -> pc=0, go FETCH; else stay.
REQ-015 FETCH: imem_req=1, imem_addr=pc; on imem_ack=1 latch imem_rdata into instr, go EXEC next cycle.
REQ-016 EXEC: instr_valid=1, opcode=instr[31:26]; control inputs sampled this state.
REQ-017 EXEC with stall=1 SHALL hold state, pc, instr; instr_valid stays 1.
REQ-018 EXEC with stall=0 SHALL load next pc and go FETCH, or go HALT if Stop=1.
REQ-019 Next-pc priority: Stop (no pc update) > JumpReg (reg_target[ADDR_W-1:0]) > Jump (instr[ADDR_W-1:0]) > Branch&branch_taken (pc+1+sext(instr[15:0])) > pc+1.
REQ-020 All pc arithmetic SHALL be modulo 2^ADDR_W; pc+1 at all-ones wraps to 0.
REQ-021 pc_link SHALL equal pc+1 (modulo) whenever instr_valid=1.
REQ-022 HALT: halted=1, imem_req=0, instr_valid=0; start=1 -> pc=0, fault cleared, go FETCH.
REQ-023 Fetch latency: imem_req rises the cycle after entering FETCH; minimum fetch-to-EXEC = 2 cycles (ack same cycle as req).
REQ-024 start while in FETCH or EXEC SHALL be ignored.
REQ-025 imem_ack outside FETCH SHALL be ignored.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, pc=0, instr=0, imem_req=0, instr_valid=0, halted=0, fault=0, timeout counter=0, regardless of state (mid-fetch request abandoned).

Configuration
REQ-027 With FETCH_TIMEOUT_EN defined: counter counts FETCH cycles without ack; reaching TIMEOUT -> fault=1, go HALT.
REQ-028 Without FETCH_TIMEOUT_EN: FETCH waits indefinitely; fault tied 0; no counter logic.

Structure
REQ-029 Shared package proc_pkg SHALL hold opcode constants, instruction field positions (opcode 31:26, imm 15:0), and the fetch state enum.
REQ-030 Next-pc mux/adder SHALL be sub-module next_pc_calc (combinational, parameterised ADDR_W).

Verification
REQ-031 Reset, start, memory with 0-wait ack, opcodes add,add,NOP at 0..2 -> instr_valid at pc 0,1,2; halted=1 after pc 2.
REQ-032 j at pc 3 with target 0x040 -> next imem_addr=0x040.
REQ-033 beq at pc 10, imm=0xFFFE, branch_taken=1 -> next pc 9; branch_taken=0 -> pc 11.
REQ-034 jr with reg_target=0x12345 (ADDR_W=10) -> pc 0x345; jal at pc 0x3FF -> pc_link=0.
REQ-035 stall=1 for 5 EXEC cycles -> pc, instr stable, no imem_req; rst asserted mid-FETCH -> IDLE, imem_req=0 next cycle.
REQ-036 FETCH_TIMEOUT_EN, TIMEOUT=4, no ack -> fault=1, halted=1 after 4 FETCH cycles; start clears fault.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor definitions: opcodes, instruction field positions, fetch FSM states.
package proc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC select and adders, purely combinational (0 cycles); priority jr > j > taken branch > pc+1.
module next_pc_calc
  import proc_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       instr,
  input  logic [31:0]       reg_target,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic              branch,
  input  logic              branch_taken,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic [ADDR_W-1:0] next_pc
);

  logic [15:0]       imm;
  logic [ADDR_W-1:0] imm_sext;
  logic              unused_bits;

  assign imm = instr[IMM_MSB:IMM_LSB];

  // Sign-extend or truncate the 16-bit offset to ADDR_W; wrap-around is intended.
  always_comb begin
    imm_sext = '0;
    for (int i = 0; i < ADDR_W; i++) imm_sext[i] = imm[(i < 16) ? i : 15];
  end

  assign pc_plus1 = pc + ADDR_W'(1);

  always_comb begin
    next_pc = pc_plus1;
    if (jump_reg)                 next_pc = reg_target[ADDR_W-1:0];
    else if (jump)                next_pc = instr[ADDR_W-1:0];
    else if (branch && branch_taken) next_pc = pc_plus1 + imm_sext;
  end

  assign unused_bits = ^{instr, reg_target};

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch FSM: request imem at pc, hold instr during EXEC (stall freezes it), minimum 2 cycles fetch-to-EXEC.
// Optional FETCH_TIMEOUT_EN: fault and halt after TIMEOUT un-acked FETCH cycles.
module instr_fetch
  import proc_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              Jump,
  input  logic              JumpReg,
  input  logic              Branch,
  input  logic              Stop,
  input  logic              JAL,
  input  logic              branch_taken,
  input  logic [31:0]       reg_target,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_link,
  output logic              halted,
  output logic              fault
);

  fetch_state_t      state, state_nx;
  logic [ADDR_W-1:0] pc_nx, pc_plus1, target;
  logic [31:0]       instr_nx;
  logic              timeout_hit;
  logic              unused_jal;

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc          (pc),
    .instr       (instr),
    .reg_target  (reg_target),
    .jump        (Jump),
    .jump_reg    (JumpReg),
    .branch      (Branch),
    .branch_taken(branch_taken),
    .pc_plus1    (pc_plus1),
    .next_pc     (target)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
  logic             fault_q;

  assign timeout_hit = (state == S_FETCH) && !imem_ack && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      fault_q <= 1'b0;
    end else begin
      if (state == S_FETCH && !imem_ack) cnt <= cnt + 1'b1;
      else                               cnt <= '0;
      if (timeout_hit)                   fault_q <= 1'b1;
      else if (state == S_HALT && start) fault_q <= 1'b0;
    end
  end

  assign fault = fault_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign fault          = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    instr_nx = instr;
    unique case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_nx    = '0;
          state_nx = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_nx = imem_rdata;
          state_nx = S_EXEC;
        end else if (timeout_hit) begin
          state_nx = S_HALT;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          if (Stop) begin
            state_nx = S_HALT;
          end else begin
            pc_nx    = target;
            state_nx = S_FETCH;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      instr <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      instr <= instr_nx;
    end
  end

  assign imem_req    = (state == S_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_EXEC);
  assign halted      = (state == S_HALT);
  assign opcode      = instr[OPC_MSB:OPC_LSB];
  assign pc_link     = pc_plus1;
  assign unused_jal  = JAL;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a zero-wait instruction memory model.
module tb_instr_fetch;
  import proc_pkg::*;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst, start, Jump, JumpReg, Branch, Stop, JAL, branch_taken, stall;
  logic [31:0]       reg_target;
  logic              imem_req, imem_ack, instr_valid, halted, fault;
  logic [ADDR_W-1:0] imem_addr, pc, pc_link;
  logic [31:0]       imem_rdata, instr;
  logic [5:0]        opcode;

  logic [31:0] mem [0:1023];
  logic        ack_en, ack_force, rdata_bad;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  assign imem_ack   = ack_force | (imem_req & ack_en);
  assign imem_rdata = rdata_bad ? 32'hDEADBEEF : mem[imem_addr];

  instr_fetch #(.ADDR_W(ADDR_W), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .Jump(Jump), .JumpReg(JumpReg), .Branch(Branch), .Stop(Stop), .JAL(JAL),
    .branch_taken(branch_taken), .reg_target(reg_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
    .pc(pc), .pc_link(pc_link), .halted(halted), .fault(fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 20) begin
      step();
      n++;
    end
    if (!instr_valid) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  // Execute one instruction: check its pc, apply control, then check the next fetch address.
  task automatic exec(input string tag, input logic [31:0] exp_pc, input logic j, input logic jr,
                      input logic br, input logic bt, input logic [31:0] regt,
                      input logic [31:0] exp_next);
    wait_valid();
    check({tag, "_pc"}, pc, exp_pc);
    Jump = j; JumpReg = jr; Branch = br; branch_taken = bt; reg_target = regt;
    step();
    Jump = 0; JumpReg = 0; Branch = 0; branch_taken = 0; reg_target = '0;
    check({tag, "_next"}, imem_addr, exp_next);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]     = 32'h00221820;
    mem[1]     = 32'h00642020;
    mem[2]     = 32'h00000000;
    mem[3]     = {OP_J, 26'h040};
    mem[5]     = 32'h00851020;
    mem[9]     = {OP_J, 26'd10};
    mem[10]    = {OP_BEQ, 5'd1, 5'd2, 16'hFFFE};
    mem[11]    = {OP_RTYPE, 5'd4, 15'd0, 6'h08};
    mem[12'h040] = {OP_J, 26'd10};
    mem[12'h345] = {OP_J, 26'h3FF};
    mem[12'h3FF] = {OP_JAL, 26'h005};

    rst = 1; start = 0; Jump = 0; JumpReg = 0; Branch = 0; Stop = 0; JAL = 0;
    branch_taken = 0; reg_target = '0; stall = 0;
    ack_en = 1; ack_force = 0; rdata_bad = 0;
    step(); step();
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    check("rst_pc", pc, 0);
    check("rst_instr", instr, 0);
    rst = 0;
    step();
    check("idle_no_req", imem_req, 0);

    // add, add, NOP with zero-wait memory; Stop on the NOP halts at pc 2
    start = 1;
    step();
    start = 0;
    check("fetch0_req", imem_req, 1);
    check("fetch0_addr", imem_addr, 0);
    check("fetch0_valid", instr_valid, 0);
    step();
    check("exec0_valid", instr_valid, 1);
    check("exec0_instr", instr, 32'h00221820);
    check("exec0_opcode", opcode, 0);
    check("exec0_link", pc_link, 1);
    exec("add0", 0, 0, 0, 0, 0, 0, 1);
    exec("add1", 1, 0, 0, 0, 0, 0, 2);
    wait_valid();
    check("nop_pc", pc, 2);
    check("nop_instr", instr, 0);
    Stop = 1;
    step();
    Stop = 0;
    check("halt_halted", halted, 1);
    check("halt_req", imem_req, 0);
    check("halt_valid", instr_valid, 0);
    check("halt_pc", pc, 2);

    // restart from HALT, then jumps / branches / jr / jal
    start = 1;
    step();
    start = 0;
    check("restart_req", imem_req, 1);
    check("restart_addr", imem_addr, 0);
    exec("jr_to3", 0, 0, 1, 0, 0, 3, 3);
    exec("j_040", 3, 1, 0, 0, 0, 0, 32'h040);
    exec("j_10", 32'h040, 1, 0, 0, 0, 0, 10);
    exec("beq_taken", 10, 0, 0, 1, 1, 0, 9);
    exec("j_10b", 9, 1, 0, 0, 0, 0, 10);
    exec("beq_not", 10, 0, 0, 1, 0, 0, 11);
    exec("jr_over_j", 11, 1, 1, 1, 1, 32'h12345, 32'h345);
    exec("j_3ff", 32'h345, 1, 0, 0, 0, 0, 32'h3FF);
    wait_valid();
    check("jal_link_wrap", pc_link, 0);
    JAL = 1;
    exec("jal", 32'h3FF, 1, 0, 0, 0, 0, 5);
    JAL = 0;

    // stall for 5 EXEC cycles; start and a stray ack must be ignored
    wait_valid();
    check("stall_pc0", pc, 5);
    stall = 1; start = 1; ack_force = 1; rdata_bad = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_pc", pc, 5);
      check("stall_instr", instr, 32'h00851020);
      check("stall_req", imem_req, 0);
      check("stall_valid", instr_valid, 1);
    end
    stall = 0; start = 0; ack_force = 0; rdata_bad = 0; ack_en = 0;
    step();
    check("fetch6_addr", imem_addr, 6);

    // memory never acks
    for (int i = 0; i < 4; i++) begin
      check("wait_req", imem_req, 1);
      step();
    end
`ifdef FETCH_TIMEOUT_EN
    check("to_fault", fault, 1);
    check("to_halted", halted, 1);
`else
    check("nto_fault", fault, 0);
    check("nto_halted", halted, 0);
`endif
    start = 1;
    step();
    start = 0;
    check("post_start_fault", fault, 0);
    check("post_start_req", imem_req, 1);
`ifdef FETCH_TIMEOUT_EN
    check("post_start_pc", pc, 0);
`else
    check("start_in_fetch_pc", pc, 6);
`endif

    // reset mid-FETCH
    rst = 1;
    step();
    check("midrst_req", imem_req, 0);
    check("midrst_valid", instr_valid, 0);
    check("midrst_pc", pc, 0);
    check("midrst_instr", instr, 0);
    check("midrst_halted", halted, 0);
    check("midrst_fault", fault, 0);
    rst = 0; ack_en = 1;
    step();
    check("midrst_idle_req", imem_req, 0);
    start = 1;
    step();
    start = 0;
    wait_valid();
    check("refetch_instr", instr, 32'h00221820);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
